// File: rtl/grid_mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grid_mem_arbiter_if                                              |
// | Requester and memory-side signal bundle for grid_mem_arbiter.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface grid_mem_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 5
);
   logic [N_REQ-1:0]        i_req;
   logic [N_REQ-1:0]        i_lock;
   logic [N_REQ-1:0]        i_we;
   logic [N_REQ*ADDR_W-1:0] i_addr;
   logic [N_REQ*DATA_W-1:0] i_wdata;
   logic [N_REQ-1:0]        o_gnt;
   logic [N_REQ-1:0]        o_rvalid;
   logic [DATA_W-1:0]       o_rdata;
   logic                    o_mem_en;
   logic                    o_mem_we;
   logic [ADDR_W-1:0]       o_mem_addr;
   logic [DATA_W-1:0]       o_mem_wdata;
   logic [DATA_W-1:0]       i_mem_rdata;
   logic                    o_lock_err;
   logic                    o_busy;

   modport master (
      output i_req, i_lock, i_we, i_addr, i_wdata, i_mem_rdata,
      input  o_gnt, o_rvalid, o_rdata, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
      input  o_lock_err, o_busy
   );

   modport slave (
      input  i_req, i_lock, i_we, i_addr, i_wdata, i_mem_rdata,
      output o_gnt, o_rvalid, o_rdata, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
      output o_lock_err, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/grid_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grid_mem_arbiter                                                 |
// | Round-robin, lockable arbiter for the single-port sudoku memory. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module grid_mem_arbiter #(
   parameter int N_REQ    = 3,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 5,
   parameter int RD_LAT   = 1,
   parameter int MAX_LOCK = 16
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   grid_mem_arbiter_if.slave bus
);

   localparam int         c_IDX_W  = (N_REQ > 2) ? 2 : 1;
   localparam int         c_DST_W  = c_IDX_W + 1;
   localparam int         c_CNT_W  = $clog2(MAX_LOCK) + 1;
   localparam logic [0:0] c_FREE   = 1'b0;
   localparam logic [0:0] c_LOCKED = 1'b1;

   logic [0:0]                     r_state;
   logic [0:0]                     w_state_nxt;
   logic [c_IDX_W-1:0]             r_owner;
   logic [c_IDX_W-1:0]             w_owner_nxt;
   logic [c_IDX_W-1:0]             r_rr_last;
   logic [c_IDX_W-1:0]             w_rr_nxt;
   logic [c_CNT_W-1:0]             r_lock_cnt;
   logic [c_CNT_W-1:0]             w_cnt_nxt;
   logic [RD_LAT-1:0]              r_pipe_vld;
   logic [RD_LAT-1:0][c_IDX_W-1:0] r_pipe_id;

   logic [N_REQ-1:0][c_DST_W-1:0]  w_dist;
   logic                           w_win_hit;
   logic [c_IDX_W-1:0]             w_win_idx;
   logic [c_DST_W-1:0]             w_best;
   logic                           w_cnt_max;
   logic                           w_gnt_vld;
   logic [c_IDX_W-1:0]             w_gnt_idx;
   logic [N_REQ-1:0]               w_gnt;
   logic [N_REQ-1:0]               w_rvalid;
   logic                           w_mem_we;
   logic [ADDR_W-1:0]              w_mem_addr;
   logic [DATA_W-1:0]              w_mem_wdata;
   logic                           w_rd_issue;
   logic                           w_lock_err;

   // Search distance of each requester from the last winner: 1 = next in line, N_REQ = last winner itself.
   generate
      for (genvar gj = 0; gj < N_REQ; gj++) begin : g_dist
         localparam logic [c_DST_W-1:0] c_J = c_DST_W'(gj);
         assign w_dist[gj] = (c_J > {1'b0, r_rr_last}) ? (c_J - {1'b0, r_rr_last})
                                                      : (c_J + c_DST_W'(N_REQ) - {1'b0, r_rr_last});
      end
   endgenerate

   always_comb begin
      w_win_hit = 1'b0;
      w_win_idx = '0;
      w_best    = '1;
      for (int j = 0; j < N_REQ; j++) begin
         if (bus.i_req[j] && (w_dist[j] < w_best)) begin
            w_best    = w_dist[j];
            w_win_idx = c_IDX_W'(j);
            w_win_hit = 1'b1;
         end
      end
   end

   assign w_cnt_max = (r_lock_cnt == c_CNT_W'(MAX_LOCK - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_FREE;
         r_owner    <= '0;
         r_rr_last  <= c_IDX_W'(N_REQ - 1);
         r_lock_cnt <= '0;
         r_pipe_vld <= '0;
         r_pipe_id  <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_owner       <= w_owner_nxt;
         r_rr_last     <= w_rr_nxt;
         r_lock_cnt    <= w_cnt_nxt;
         r_pipe_vld[0] <= w_rd_issue;
         r_pipe_id[0]  <= w_gnt_idx;
         for (int s = 1; s < RD_LAT; s++) begin
            r_pipe_vld[s] <= r_pipe_vld[s-1];
            r_pipe_id[s]  <= r_pipe_id[s-1];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_rr_nxt    = r_rr_last;
      w_cnt_nxt   = r_lock_cnt;
      case (r_state)
         c_FREE: begin
            if (w_win_hit) begin
               w_rr_nxt = w_win_idx;
               if (bus.i_lock[w_win_idx]) begin
                  w_state_nxt = c_LOCKED;
                  w_owner_nxt = w_win_idx;
                  w_cnt_nxt   = '0;
               end
            end
         end
         c_LOCKED: begin
            w_cnt_nxt = r_lock_cnt + 1'b1;
            // Voluntary and forced release both hand lowest priority to the owner.
            if (!bus.i_lock[r_owner] || w_cnt_max) begin
               w_state_nxt = c_FREE;
               w_rr_nxt    = r_owner;
            end
         end
         default: w_state_nxt = c_FREE;
      endcase
   end

   always_comb begin
      w_gnt_idx = w_win_idx;
      w_gnt_vld = w_win_hit;
      if (r_state == c_LOCKED) begin
         w_gnt_idx = r_owner;
         w_gnt_vld = bus.i_req[r_owner];
      end
      if (!rst_n) begin
         w_gnt_vld = 1'b0;
      end
      w_gnt       = '0;
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (w_gnt_vld && (w_gnt_idx == c_IDX_W'(j))) begin
            w_gnt[j]    = 1'b1;
            w_mem_we    = bus.i_we[j];
            w_mem_addr  = bus.i_addr[j*ADDR_W +: ADDR_W];
            w_mem_wdata = bus.i_wdata[j*DATA_W +: DATA_W];
         end
      end
      w_rd_issue = w_gnt_vld && !w_mem_we;
      w_lock_err = rst_n && (r_state == c_LOCKED) && bus.i_lock[r_owner] && w_cnt_max;
      w_rvalid   = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (r_pipe_vld[RD_LAT-1] && (r_pipe_id[RD_LAT-1] == c_IDX_W'(j))) begin
            w_rvalid[j] = 1'b1;
         end
      end
   end

   assign bus.o_gnt       = w_gnt;
   assign bus.o_rvalid    = w_rvalid;
   assign bus.o_rdata     = r_pipe_vld[RD_LAT-1] ? bus.i_mem_rdata : '0;
   assign bus.o_mem_en    = w_gnt_vld;
   assign bus.o_mem_we    = w_mem_we;
   assign bus.o_mem_addr  = w_mem_addr;
   assign bus.o_mem_wdata = w_mem_wdata;
   assign bus.o_lock_err  = w_lock_err;
   assign bus.o_busy      = (r_state == c_LOCKED) || (|r_pipe_vld);

endmodule
`default_nettype wire

// File: tb/tb_grid_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_grid_mem_arbiter                                              |
// | Scoreboard bench for grid_mem_arbiter with a behavioural model.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_grid_mem_arbiter;
   localparam int N_REQ    = 3;
   localparam int ADDR_W   = 7;
   localparam int DATA_W   = 5;
   localparam int RD_LAT   = 2;
   localparam int MAX_LOCK = 16;

   typedef struct {
      logic [N_REQ-1:0]  gnt;
      logic              en;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              lerr;
      logic              busy;
      logic              in_rst;
   } cyc_t;

   typedef struct {
      int                id;
      int                due;
      logic [DATA_W-1:0] data;
   } rd_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   grid_mem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   grid_mem_arbiter #(
      .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Write-first single-port memory with RD_LAT read latency.
   logic [DATA_W-1:0] mem      [128];
   logic [DATA_W-1:0] mem_pipe [RD_LAT];
   always @(posedge clk) begin
      if (bus.o_mem_en && bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      mem_pipe[0] <= (bus.o_mem_en && !bus.o_mem_we) ? mem[bus.o_mem_addr] : '0;
      for (int s = 1; s < RD_LAT; s++) mem_pipe[s] <= mem_pipe[s-1];
   end
   assign bus.i_mem_rdata = mem_pipe[RD_LAT-1];

   cyc_t              exp_q[$];
   rd_t               rd_q[$];
   logic [DATA_W-1:0] shadow [128];
   int                n_checks = 0;
   int                n_fail   = 0;
   int                cyc      = 0;
   bit                m_locked = 1'b0;
   int                m_owner  = 0;
   int                m_cnt    = 0;
   int                m_rr     = N_REQ - 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit bit_at(input logic [N_REQ-1:0] v, input int i);
      logic [N_REQ-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   // Spec-level model: one access per cycle, round robin after the last winner, lock ownership with timeout.
   task automatic model_cycle();
      cyc_t e;
      rd_t  r;
      int   g;
      g        = -1;
      e.gnt    = '0;
      e.en     = 1'b0;
      e.we     = 1'b0;
      e.addr   = '0;
      e.wdata  = '0;
      e.lerr   = 1'b0;
      e.busy   = 1'b0;
      e.in_rst = !rst_n;
      if (!rst_n) begin
         m_locked = 1'b0;
         m_rr     = N_REQ - 1;
         m_cnt    = 0;
         rd_q.delete();
      end else begin
         e.busy = m_locked || (rd_q.size() != 0);
         if (m_locked) begin
            if (bit_at(bus.i_req, m_owner)) g = m_owner;
            if (!bit_at(bus.i_lock, m_owner)) begin
               m_locked = 1'b0;
               m_rr     = m_owner;
            end else if (m_cnt == MAX_LOCK - 1) begin
               e.lerr   = 1'b1;
               m_locked = 1'b0;
               m_rr     = m_owner;
            end else begin
               m_cnt++;
            end
         end else begin
            for (int k = 1; k <= N_REQ; k++)
               if (g < 0 && bit_at(bus.i_req, (m_rr + k) % N_REQ)) g = (m_rr + k) % N_REQ;
            if (g >= 0) begin
               m_rr = g;
               if (bit_at(bus.i_lock, g)) begin
                  m_locked = 1'b1;
                  m_owner  = g;
                  m_cnt    = 0;
               end
            end
         end
         if (g >= 0) begin
            e.gnt   = N_REQ'(1 << g);
            e.en    = 1'b1;
            e.we    = bit_at(bus.i_we, g);
            e.addr  = ADDR_W'(bus.i_addr >> (g * ADDR_W));
            e.wdata = DATA_W'(bus.i_wdata >> (g * DATA_W));
            if (e.we) begin
               shadow[e.addr] = e.wdata;
            end else begin
               r.id   = g;
               r.due  = cyc + RD_LAT;
               r.data = shadow[e.addr];
               rd_q.push_back(r);
            end
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic step(input logic rn, input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] lock,
                       input logic [N_REQ-1:0] we, input logic [N_REQ*ADDR_W-1:0] addr,
                       input logic [N_REQ*DATA_W-1:0] wd);
      @(negedge clk);
      cyc++;
      rst_n       = rn;
      bus.i_req   = req;
      bus.i_lock  = lock;
      bus.i_we    = we;
      bus.i_addr  = addr;
      bus.i_wdata = wd;
      #1 model_cycle();
   endtask

   function automatic logic [N_REQ*ADDR_W-1:0] rnd_addr();
      return {ADDR_W'($urandom_range(80)), ADDR_W'($urandom_range(80)), ADDR_W'($urandom_range(80))};
   endfunction

   function automatic logic [N_REQ*DATA_W-1:0] rnd_data();
      return N_REQ*DATA_W'($urandom);
   endfunction

   // Monitor: compares each cycle's outputs and every read return against the queued expectations.
   initial begin : monitor
      cyc_t e;
      rd_t  r;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("gnt",       32'(bus.o_gnt),       32'(e.gnt));
            chk("mem_en",    32'(bus.o_mem_en),    32'(e.en));
            chk("mem_we",    32'(bus.o_mem_we),    32'(e.we));
            chk("mem_addr",  32'(bus.o_mem_addr),  32'(e.addr));
            chk("mem_wdata", 32'(bus.o_mem_wdata), 32'(e.wdata));
            chk("lock_err",  32'(bus.o_lock_err),  32'(e.lerr));
            chk("busy",      32'(bus.o_busy),      32'(e.busy));
            if (e.in_rst) chk("rdata_in_reset", 32'(bus.o_rdata), 32'd0);
         end
         if (bus.o_rvalid != '0) begin
            if (rd_q.size() == 0) begin
               chk("rvalid_unexpected", 32'(bus.o_rvalid), 32'd0);
            end else begin
               r = rd_q.pop_front();
               chk("rvalid_id",    32'(bus.o_rvalid), 32'(1 << r.id));
               chk("rdata",        32'(bus.o_rdata),  32'(r.data));
               chk("rvalid_cycle", 32'(cyc),          32'(r.due));
            end
         end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            chk("rvalid_missing", 32'(bus.o_rvalid), 32'(1 << r.id));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "time limit reached");
   end

   initial begin : driver
      bus.i_req   = '0;
      bus.i_lock  = '0;
      bus.i_we    = '0;
      bus.i_addr  = '0;
      bus.i_wdata = '0;
      repeat (3) step(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);

      // Host fills every cell, then a reset with all requests active must keep outputs quiet.
      for (int a = 0; a < 81; a++)
         step(1'b1, 3'b001, 3'b000, 3'b001, {14'd0, ADDR_W'(a)}, {10'd0, DATA_W'($urandom)});
      repeat (2) step(1'b0, 3'b111, 3'b111, 3'b000, rnd_addr(), rnd_data());

      // Round robin from reset, all reads.
      repeat (6) step(1'b1, 3'b111, 3'b000, 3'b000, rnd_addr(), rnd_data());
      step(1'b1, 3'b001, 3'b000, 3'b000, rnd_addr(), rnd_data());

      // Lock by req1: read cell 5, write 0x13 while releasing, then read it back.
      step(1'b1, 3'b111, 3'b010, 3'b000, {7'd9, 7'd5, 7'd3}, '0);
      step(1'b1, 3'b111, 3'b000, 3'b010, {7'd9, 7'd5, 7'd3}, {5'd0, 5'h13, 5'd0});
      step(1'b1, 3'b111, 3'b000, 3'b000, {7'd9, 7'd5, 7'd3}, '0);
      step(1'b1, 3'b010, 3'b000, 3'b000, {7'd9, 7'd5, 7'd3}, '0);

      // req2 owns the port while its own request toggles.
      step(1'b1, 3'b010, 3'b000, 3'b000, rnd_addr(), rnd_data());
      step(1'b1, 3'b101, 3'b100, 3'b000, rnd_addr(), rnd_data());
      step(1'b1, 3'b001, 3'b100, 3'b000, rnd_addr(), rnd_data());
      step(1'b1, 3'b101, 3'b100, 3'b000, rnd_addr(), rnd_data());
      step(1'b1, 3'b101, 3'b000, 3'b000, rnd_addr(), rnd_data());

      // req0 holds lock past the limit; forced release must hand the port to req1.
      repeat (20) step(1'b1, 3'b011, 3'b001, 3'b000, rnd_addr(), rnd_data());
      repeat (3) step(1'b1, 3'b011, 3'b000, 3'b000, rnd_addr(), rnd_data());

      // Back-to-back reads from all three requesters.
      step(1'b1, 3'b100, 3'b000, 3'b100, rnd_addr(), rnd_data());
      repeat (3) step(1'b1, 3'b111, 3'b000, 3'b000, {7'd70, 7'd40, 7'd12}, '0);
      repeat (3) step(1'b1, 3'b000, 3'b000, 3'b000, '0, '0);

      // Reset one cycle after a locked read: the read is dropped, req0 wins afterwards.
      step(1'b1, 3'b001, 3'b001, 3'b000, rnd_addr(), rnd_data());
      step(1'b1, 3'b001, 3'b001, 3'b000, rnd_addr(), rnd_data());
      step(1'b0, 3'b111, 3'b001, 3'b000, rnd_addr(), rnd_data());
      step(1'b0, 3'b111, 3'b001, 3'b000, rnd_addr(), rnd_data());
      step(1'b1, 3'b111, 3'b000, 3'b000, rnd_addr(), rnd_data());

      // Random traffic: short locks first, then long-held locks that reach the timeout.
      repeat (300) step(1'b1, 3'($urandom), 3'($urandom & $urandom & $urandom), 3'($urandom),
                        rnd_addr(), rnd_data());
      repeat (300) step(1'b1, 3'($urandom), 3'($urandom | $urandom | $urandom), 3'($urandom),
                        rnd_addr(), rnd_data());

      repeat (RD_LAT + 3) step(1'b1, 3'b000, 3'b000, 3'b000, '0, '0);
      #3;
      chk("reads_outstanding", 32'(rd_q.size()), 32'd0);
      chk("cycles_unchecked",  32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
